parity_engine: RTL and testbench

Parametrised multi-cycle parity generator with a start/busy/done handshake, the successor to the fixed 8-bit `parity` unit. It captures a WIDTH-bit word on `start` and folds BITS_PER_CYCLE bits per clock into a running XOR. On completion it presents registered even- and odd-parity bits and pulses `done`. It sits between a data source and a serialiser or link checker that needs a parity bit per word.

---
 rtl/parity_engine.sv | 104 ++++++++++
 tb/tb_parity_engine.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/parity_engine.sv
// Multi-cycle parity generator: captures a WIDTH-bit word on start and folds
// BITS_PER_CYCLE bits per clock into a running XOR. Optional check: PARITY_CHECK_EN.
module parity_engine #(
   parameter int WIDTH          = 8,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
`ifdef PARITY_CHECK_EN
   input  logic             check_in,
   output logic             parity_err,
`endif
   output logic             even_parity,
   output logic             odd_parity,
   output logic             busy,
   output logic             done
);

   localparam int N  = WIDTH / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg;
   logic             acc, acc_nxt;
   logic [CW-1:0]    cnt;
   logic             load, last;
`ifdef PARITY_CHECK_EN
   logic             chk_q;
`endif

   // Fold the low slice of the shift register into the running parity.
   assign acc_nxt = acc ^ (^shreg[BITS_PER_CYCLE-1:0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      last      = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (cnt == CW'(1)) begin
               last      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg       <= '0;
         acc         <= 1'b0;
         cnt         <= '0;
         done        <= 1'b0;
         even_parity <= 1'b0;
         odd_parity  <= 1'b1;
`ifdef PARITY_CHECK_EN
         chk_q       <= 1'b0;
         parity_err  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (load) begin
            shreg <= data_in;
            acc   <= 1'b0;
            cnt   <= CW'(N);
`ifdef PARITY_CHECK_EN
            chk_q <= check_in;
`endif
         end else if (busy) begin
            acc   <= acc_nxt;
            shreg <= shreg >> BITS_PER_CYCLE;
            cnt   <= cnt - CW'(1);
            // Results only move on completion; they hold across the next start.
            if (last) begin
               even_parity <= acc_nxt;
               odd_parity  <= ~acc_nxt;
               done        <= 1'b1;
`ifdef PARITY_CHECK_EN
               parity_err  <= acc_nxt ^ chk_q;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_parity_engine.sv
// Directed bench for parity_engine: 8/1 and 16/4 instances, plus an 8/2 instance
// exercising the mismatch flag when PARITY_CHECK_EN is defined.
module tb_parity_engine;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
   logic [7:0]  data_a = '0, data_c = '0;
   logic [15:0] data_b = '0;
   logic        even_a, odd_a, busy_a, done_a;
   logic        even_b, odd_b, busy_b, done_b;
   int          n_chk = 0;
   int          n_err = 0;
`ifdef PARITY_CHECK_EN
   logic        check_in = 1'b0;
   logic        err_a, err_b, err_c;
   logic        even_c, odd_c, busy_c, done_c;
`endif

   always #5 clk = ~clk;

   parity_engine #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .data_in(data_a),
`ifdef PARITY_CHECK_EN
      .check_in(check_in), .parity_err(err_a),
`endif
      .even_parity(even_a), .odd_parity(odd_a), .busy(busy_a), .done(done_a));

   parity_engine #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .data_in(data_b),
`ifdef PARITY_CHECK_EN
      .check_in(check_in), .parity_err(err_b),
`endif
      .even_parity(even_b), .odd_parity(odd_b), .busy(busy_b), .done(done_b));

`ifdef PARITY_CHECK_EN
   parity_engine #(.WIDTH(8), .BITS_PER_CYCLE(2)) u_c (
      .clk(clk), .rst_n(rst_n), .start(start_c), .data_in(data_c),
      .check_in(check_in), .parity_err(err_c),
      .even_parity(even_c), .odd_parity(odd_c), .busy(busy_c), .done(done_c));
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic busy_of(input int sel);
      case (sel)
         0:       return busy_a;
         1:       return busy_b;
`ifdef PARITY_CHECK_EN
         2:       return busy_c;
`endif
         default: return 1'b0;
      endcase
   endfunction

   // One-cycle start, then count busy cycles; ends on the first non-busy negedge.
   // With poke set, start is pulsed with junk data while the engine is busy.
   task automatic run_op(input int sel, input logic [15:0] d, input bit poke, output int bc);
      @(negedge clk);
      case (sel)
         0:       begin start_a = 1'b1; data_a = d[7:0]; end
         1:       begin start_b = 1'b1; data_b = d;      end
         default: begin start_c = 1'b1; data_c = d[7:0]; end
      endcase
      @(posedge clk);
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      bc = 0;
      while (busy_of(sel) && bc < 100) begin
         bc++;
         if (poke && bc == 1) begin start_b = 1'b1; data_b = 16'hFFFF; end
         if (poke && bc == 2) start_b = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      int bc, k;
      // Reset state
      #12;
      chk("rst_even", even_a, 1'b0);
      chk("rst_odd", odd_a, 1'b1);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_done", done_a, 1'b0);
`ifdef PARITY_CHECK_EN
      chk("rst_err", err_c, 1'b0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // 8'hA5, four ones
      run_op(0, 16'h00A5, 1'b0, bc);
      chk("a5_busy_cycles", bc, 8);
      chk("a5_done", done_a, 1'b1);
      chk("a5_even", even_a, 1'b0);
      chk("a5_odd", odd_a, 1'b1);
      @(negedge clk);
      chk("a5_done_pulse", done_a, 1'b0);

      // Start held high: 8'h07 then 8'h00 back to back
      start_a = 1'b1; data_a = 8'h07;
      k = 0;
      do begin @(negedge clk); k++; end while (!done_a && k < 50);
      chk("b2b_first_lat", k, 9);
      chk("b2b_first_even", even_a, 1'b1);
      chk("b2b_first_odd", odd_a, 1'b0);
      chk("b2b_first_busy", busy_a, 1'b0);
      data_a = 8'h00;
      @(negedge clk);
      chk("b2b_relaunch_busy", busy_a, 1'b1);
      chk("b2b_relaunch_done", done_a, 1'b0);
      chk("b2b_hold_even", even_a, 1'b1);
      k = 1;
      while (!done_a && k < 50) begin @(negedge clk); k++; end
      start_a = 1'b0;
      chk("b2b_period", k, 9);
      chk("b2b_second_even", even_a, 1'b0);
      chk("b2b_second_odd", odd_a, 1'b1);

      // 16/4: 16'h0001, with a start pulse carrying 16'hFFFF while busy
      run_op(1, 16'h0001, 1'b1, bc);
      chk("w16_busy_cycles", bc, 4);
      chk("w16_done", done_b, 1'b1);
      chk("w16_even", even_b, 1'b1);
      chk("w16_odd", odd_b, 1'b0);
      @(negedge clk);
      chk("w16_no_relaunch", busy_b, 1'b0);

      // Reset mid-op after a result of even=1
      run_op(0, 16'h0001, 1'b0, bc);
      chk("pre_rst_even", even_a, 1'b1);
      @(negedge clk);
      start_a = 1'b1; data_a = 8'hFF;
      @(posedge clk);
      @(negedge clk);
      start_a = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_busy_c3", busy_a, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy_a, 1'b0);
      chk("mid_rst_done", done_a, 1'b0);
      chk("mid_rst_even", even_a, 1'b0);
      chk("mid_rst_odd", odd_a, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done_a || busy_a) k++;
      end
      chk("post_rst_quiet", k, 0);

      // Idle hold after a completion of 8'h07
      run_op(0, 16'h0007, 1'b0, bc);
      chk("hold_setup_even", even_a, 1'b1);
      k = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (even_a !== 1'b1 || odd_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) k++;
      end
      chk("idle_hold", k, 0);

`ifdef PARITY_CHECK_EN
      // 8/2 mismatch flag
      check_in = 1'b1;
      run_op(2, 16'h00A5, 1'b0, bc);
      chk("chk_a5_busy", bc, 4);
      chk("chk_a5_done", done_c, 1'b1);
      chk("chk_a5_err", err_c, 1'b1);
      run_op(2, 16'h0007, 1'b0, bc);
      chk("chk_07_err", err_c, 1'b0);
      chk("chk_07_even", even_c, 1'b1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
